// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the byte-lane data RAM.
// One request in flight: accept in IDLE, drive the RAM for one ACCESS cycle, then respond.
module dmem_arbiter #(
   parameter int W = 32,
   parameter int H = 8,
   parameter int L = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         p0_valid,
   output logic         p0_ready,
   input  logic         p0_we,
   input  logic [L-1:0] p0_type,
   input  logic         p0_sign,
   input  logic [W-1:0] p0_addr,
   input  logic [W-1:0] p0_wdat,
   input  logic         p1_valid,
   output logic         p1_ready,
   input  logic         p1_we,
   input  logic [L-1:0] p1_type,
   input  logic         p1_sign,
   input  logic [W-1:0] p1_addr,
   input  logic [W-1:0] p1_wdat,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic         rsp_err,
   output logic [W-1:0] rsp_rdata,
   output logic         ram_we,
   output logic         ram_re,
   output logic [L-1:0] ram_type,
   output logic         ram_sign,
   output logic [W-1:0] ram_addr,
   output logic [W-1:0] ram_wdat,
   input  logic [W-1:0] ram_rdata
);
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [H:0] ONE = {{H{1'b0}}, 1'b1};

   state_t       state;
   logic         last_grant;
   logic         gnt_valid;
   logic         gnt_id;
   logic         sel_we;
   logic         sel_sign;
   logic         sel_err;
   logic [L-1:0] sel_type;
   logic [W-1:0] sel_addr;
   logic [W-1:0] sel_wdat;
   logic         acc_we;
   logic         acc_err;
   logic         acc_id;
   logic         ram_we_q;

   // Legal masks are contiguous from lane 0; the access may not run past the top byte.
   function automatic logic req_err(input logic [L-1:0] t, input logic [W-1:0] a);
      logic [H:0] nbytes;
      logic [H:0] last_byte;
      logic       bad_mask;
      nbytes = '0;
      for (int i = 0; i < L; i++) begin
         nbytes = nbytes + {{H{1'b0}}, t[i]};
      end
      bad_mask  = (t == '0) || ((t & (t + L'(1))) != '0);
      last_byte = {1'b0, a[H-1:0]} + nbytes - ONE;
      return bad_mask || ((a >> H) != '0) || last_byte[H];
   endfunction

   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (state == IDLE && !rst) begin
         if (p0_valid && p1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_grant;
         end else if (p0_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
         end else if (p1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
         end
      end
   end

   assign p0_ready = gnt_valid & ~gnt_id;
   assign p1_ready = gnt_valid &  gnt_id;

   assign sel_we   = gnt_id ? p1_we   : p0_we;
   assign sel_type = gnt_id ? p1_type : p0_type;
   assign sel_sign = gnt_id ? p1_sign : p0_sign;
   assign sel_addr = gnt_id ? p1_addr : p0_addr;
   assign sel_wdat = gnt_id ? p1_wdat : p0_wdat;
   assign sel_err  = req_err(sel_type, sel_addr);

   // Reset in the ACCESS cycle must keep the RAM from committing on that same edge.
   assign ram_we = ram_we_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         acc_we     <= 1'b0;
         acc_err    <= 1'b0;
         acc_id     <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_re     <= 1'b0;
         ram_type   <= '0;
         ram_sign   <= 1'b0;
         ram_addr   <= '0;
         ram_wdat   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               if (gnt_valid) begin
                  last_grant <= gnt_id;
                  acc_we     <= sel_we;
                  acc_err    <= sel_err;
                  acc_id     <= gnt_id;
                  ram_we_q   <= sel_we & ~sel_err;
                  ram_re     <= ~sel_we & ~sel_err;
                  ram_type   <= sel_type;
                  ram_sign   <= sel_sign;
                  ram_addr   <= sel_addr;
                  ram_wdat   <= sel_wdat;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               ram_we_q  <= 1'b0;
               ram_re    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_id    <= acc_id;
               rsp_err   <= acc_err;
               rsp_rdata <= (!acc_we && !acc_err) ? ram_rdata : '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-lane RAM fixture plus a byte-array reference of memory contents.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        p0_valid, p0_ready, p0_we, p0_sign;
   logic [3:0]  p0_type;
   logic [31:0] p0_addr, p0_wdat;
   logic        p1_valid, p1_ready, p1_we, p1_sign;
   logic [3:0]  p1_type;
   logic [31:0] p1_addr, p1_wdat;
   logic        rsp_valid, rsp_id, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ram_we, ram_re, ram_sign;
   logic [3:0]  ram_type;
   logic [31:0] ram_addr, ram_wdat, ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ram_act = 0;
   int p1_rdy_cnt = 0;
   int rsp1_cnt   = 0;
   int rsp_cnt    = 0;

   logic [7:0] ram_mem [0:255] = '{default: 8'h00};
   logic [7:0] ref_mem [0:255] = '{default: 8'h00};
   int         ram_top;

   typedef struct packed {
      logic        port;
      logic        we;
      logic [3:0]  ty;
      logic        sg;
      logic [31:0] ad;
      logic [31:0] wd;
   } req_t;

   dmem_arbiter #(.W(32), .H(8), .L(4)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_type(p0_type),
      .p0_sign(p0_sign), .p0_addr(p0_addr), .p0_wdat(p0_wdat),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_type(p1_type),
      .p1_sign(p1_sign), .p1_addr(p1_addr), .p1_wdat(p1_wdat),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .ram_we(ram_we), .ram_re(ram_re), .ram_type(ram_type), .ram_sign(ram_sign),
      .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we || ram_re) ram_act <= ram_act + 1;
      if (p1_ready) p1_rdy_cnt <= p1_rdy_cnt + 1;
      if (rsp_valid && rsp_id) rsp1_cnt <= rsp1_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   // RAM fixture: combinational lane read with optional sign extension, write on the clock edge.
   always_comb begin
      ram_rdata = '0;
      ram_top   = 0;
      for (int i = 0; i < 4; i++) begin
         if (ram_type[i]) begin
            ram_rdata[8*i +: 8] = ram_mem[ram_addr[7:0] + 8'(i)];
            ram_top = i;
         end
      end
      if (ram_sign && ram_rdata[8*ram_top+7]) begin
         for (int i = 0; i < 4; i++) begin
            if (i > ram_top) ram_rdata[8*i +: 8] = 8'hFF;
         end
      end
   end

   always @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_type[i]) ram_mem[ram_addr[7:0] + 8'(i)] <= ram_wdat[8*i +: 8];
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic int ref_nbytes(input logic [3:0] ty);
      case (ty)
         4'b0001: return 1;
         4'b0011: return 2;
         4'b0111: return 3;
         4'b1111: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit ref_err(input logic [3:0] ty, input logic [31:0] ad);
      int nb;
      nb = ref_nbytes(ty);
      return (nb == 0) || (longint'(ad) > 255) || (longint'(ad) + nb > 256);
   endfunction

   function automatic logic [31:0] ref_read(input logic [3:0] ty, input bit sg, input logic [31:0] ad);
      int     nb;
      longint v;
      nb = ref_nbytes(ty);
      v  = 0;
      for (int i = nb - 1; i >= 0; i--) v = v * 256 + ref_mem[int'(ad) + i];
      if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   task automatic model(input bit we, input logic [3:0] ty, input bit sg, input logic [31:0] ad,
                        input logic [31:0] wd, output bit e_err, output logic [31:0] e_rd);
      int nb;
      e_err = ref_err(ty, ad);
      e_rd  = '0;
      nb    = ref_nbytes(ty);
      if (!e_err) begin
         if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(ad) + i] = 8'((wd >> (8 * i)) & 32'hFF);
         end else begin
            e_rd = ref_read(ty, sg, ad);
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input bit port, input bit v, input bit we, input logic [3:0] ty,
                        input bit sg, input logic [31:0] ad, input logic [31:0] wd);
      if (!port) begin
         p0_valid = v; p0_we = we; p0_type = ty; p0_sign = sg; p0_addr = ad; p0_wdat = wd;
      end else begin
         p1_valid = v; p1_we = we; p1_type = ty; p1_sign = sg; p1_addr = ad; p1_wdat = wd;
      end
   endtask

   task automatic send(input req_t r, output int acc_cyc, output bit ok);
      drive(r.port, 1'b1, r.we, r.ty, r.sg, r.ad, r.wd);
      ok      = 1'b0;
      acc_cyc = -1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if ((r.port ? p1_ready : p0_ready) === 1'b1) begin
            ok      = 1'b1;
            acc_cyc = cyc;
         end
      end
      @(posedge clk);
      #1;
      // scramble fields after acceptance; the accepted request must not notice
      drive(r.port, 1'b0, 1'($urandom), 4'($urandom), 1'($urandom), $urandom, $urandom);
   endtask

   task automatic xact(input req_t r, output bit ok, output logic id, output logic err,
                       output logic [31:0] rd, output int lat);
      int acc;
      bit sok;
      send(r, acc, sok);
      ok = 1'b0; id = 1'bx; err = 1'bx; rd = 'x; lat = -1;
      if (sok) begin
         for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
               ok = 1'b1; id = rsp_id; err = rsp_err; rd = rsp_rdata; lat = cyc - acc;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(0, 1'b1, 1'b1, 4'hF, 1'b0, 32'h10, 32'h1);
      drive(1, 1'b1, 1'b0, 4'hF, 1'b0, 32'h14, 32'h2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({p0_ready, p1_ready, rsp_valid, rsp_id, rsp_err, ram_we, ram_re, ram_sign} !== 8'h00 ||
          {rsp_rdata, ram_addr, ram_wdat, ram_type} !== 100'h0) begin
         n_fail++;
         $display("FAIL reset_state got ctl=%b rdata=%h addr=%h wdat=%h type=%h required all zero",
                  {p0_ready, p1_ready, rsp_valid, rsp_id, rsp_err, ram_we, ram_re, ram_sign},
                  rsp_rdata, ram_addr, ram_wdat, ram_type);
      end
      drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      req_t tab [3];
      bit ok, e_err;
      logic id, err;
      logic [31:0] rd, e_rd;
      int lat;
      tab[0] = '{1'b0, 1'b1, 4'hF, 1'b0, 32'h10, 32'hDEADBEEF};
      tab[1] = '{1'b0, 1'b0, 4'hF, 1'b0, 32'h10, 32'h0};
      tab[2] = '{1'b1, 1'b0, 4'hF, 1'b0, 32'h10, 32'h0};
      foreach (tab[k]) begin
         xact(tab[k], ok, id, err, rd, lat);
         model(tab[k].we, tab[k].ty, tab[k].sg, tab[k].ad, tab[k].wd, e_err, e_rd);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL wr_rd[%0d] no accept or response within bound", k);
         end else if ({id, err, rd} !== {tab[k].port, e_err, e_rd} || lat != 2) begin
            n_fail++;
            $display("FAIL wr_rd[%0d] got id=%b err=%b rdata=%h lat=%0d required id=%b err=%b rdata=%h lat=2",
                     k, id, err, rd, lat, tab[k].port, e_err, e_rd);
         end
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_rdata} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL rsp_hold got valid=%b id=%b rdata=%h required valid=0 id=1 rdata=deadbeef",
                  rsp_valid, rsp_id, rsp_rdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sign_ext();
      req_t tab [3];
      logic [31:0] req_rd [3];
      bit ok, e_err;
      logic id, err;
      logic [31:0] rd, e_rd;
      int lat;
      tab[0] = '{1'b0, 1'b1, 4'h1, 1'b0, 32'h20, 32'h00000080};
      tab[1] = '{1'b0, 1'b0, 4'h1, 1'b1, 32'h20, 32'h0};
      tab[2] = '{1'b1, 1'b0, 4'h1, 1'b0, 32'h20, 32'h0};
      req_rd[0] = 32'h0; req_rd[1] = 32'hFFFFFF80; req_rd[2] = 32'h00000080;
      foreach (tab[k]) begin
         xact(tab[k], ok, id, err, rd, lat);
         model(tab[k].we, tab[k].ty, tab[k].sg, tab[k].ad, tab[k].wd, e_err, e_rd);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL sign_ext[%0d] no accept or response within bound", k);
         end else if ({id, err, rd} !== {tab[k].port, 1'b0, req_rd[k]} || rd !== e_rd) begin
            n_fail++;
            $display("FAIL sign_ext[%0d] got id=%b err=%b rdata=%h required id=%b err=0 rdata=%h",
                     k, id, err, rd, tab[k].port, req_rd[k]);
         end
      end
   endtask

   task automatic test_errors();
      req_t tab [7];
      bit ok, e_err;
      logic id, err;
      logic [31:0] rd, e_rd;
      int lat, act0;
      tab[0] = '{1'b0, 1'b1, 4'h5, 1'b0, 32'h10,  32'h11111111};
      tab[1] = '{1'b1, 1'b0, 4'hF, 1'b0, 32'h100, 32'h0};
      tab[2] = '{1'b0, 1'b0, 4'hF, 1'b0, 32'hFE,  32'h0};
      tab[3] = '{1'b1, 1'b1, 4'h3, 1'b0, 32'hFF,  32'h0000AAAA};
      tab[4] = '{1'b0, 1'b0, 4'hF, 1'b0, 32'h10,  32'h0};
      tab[5] = '{1'b1, 1'b1, 4'hF, 1'b0, 32'hFC,  32'h01020304};
      tab[6] = '{1'b0, 1'b0, 4'h1, 1'b1, 32'hFF,  32'h0};
      act0 = ram_act;
      foreach (tab[k]) begin
         xact(tab[k], ok, id, err, rd, lat);
         model(tab[k].we, tab[k].ty, tab[k].sg, tab[k].ad, tab[k].wd, e_err, e_rd);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL err_chk[%0d] no accept or response within bound", k);
         end else if ({id, err, rd} !== {tab[k].port, e_err, e_rd} || lat != 2) begin
            n_fail++;
            $display("FAIL err_chk[%0d] got id=%b err=%b rdata=%h lat=%0d required id=%b err=%b rdata=%h lat=2",
                     k, id, err, rd, lat, tab[k].port, e_err, e_rd);
         end
         if (k == 3) begin
            n_tests++;
            if (ram_act != act0) begin
               n_fail++;
               $display("FAIL err_no_ram got %0d RAM enable cycles required 0", ram_act - act0);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] pw [4];
      int i0, i1, nresp, last_acc, ec, rsp0;
      bit exp_port, r0, r1, e_err, gp;
      logic [31:0] e_rd;
      logic [33:0] er;
      int q_cyc [$];
      logic [33:0] q_rsp [$];
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) pw[i] = $urandom;
      i0 = 0; i1 = 0; nresp = 0; last_acc = -1; exp_port = 1'b0; rsp0 = rsp_cnt;
      drive(0, 1'b1, 1'b1, 4'hF, 1'b0, 32'h80, pw[0]);
      drive(1, 1'b1, 1'b0, 4'hF, 1'b0, 32'h80, 32'h0);
      for (int t = 0; t < 60 && nresp < 8; t++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            n_tests++;
            nresp++;
            if (q_cyc.size() == 0) begin
               n_fail++; $display("FAIL rr_rsp unexpected response id=%b at cycle %0d", rsp_id, cyc);
            end else begin
               ec = q_cyc.pop_front();
               er = q_rsp.pop_front();
               if ({rsp_id, rsp_err, rsp_rdata} !== er || cyc != ec) begin
                  n_fail++;
                  $display("FAIL rr_rsp got id/err/rdata=%h cycle=%0d required %h cycle=%0d",
                           {rsp_id, rsp_err, rsp_rdata}, cyc, er, ec);
               end
            end
         end
         r0 = p0_ready;
         r1 = p1_ready;
         if (r0 || r1) begin
            n_tests++;
            if ({r0, r1} !== (exp_port ? 2'b01 : 2'b10) || (last_acc >= 0 && cyc != last_acc + 2)) begin
               n_fail++;
               $display("FAIL rr_grant got ready=%b%b cycle=%0d required port %0d at cycle %0d",
                        r0, r1, cyc, exp_port, last_acc + 2);
            end
            gp = r1;
            if (!gp) model(1'b1, 4'hF, 1'b0, 32'h80 + 4 * i0, pw[i0], e_err, e_rd);
            else     model(1'b0, 4'hF, 1'b0, 32'h80 + 4 * i1, 32'h0, e_err, e_rd);
            q_cyc.push_back(cyc + 2);
            q_rsp.push_back({gp, e_err, e_rd});
            last_acc = cyc;
            exp_port = ~exp_port;
         end
         @(posedge clk);
         #1;
         if (r0) begin
            i0++;
            if (i0 < 4) drive(0, 1'b1, 1'b1, 4'hF, 1'b0, 32'h80 + 4 * i0, pw[i0]);
            else        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
         end
         if (r1) begin
            i1++;
            if (i1 < 4) drive(1, 1'b1, 1'b0, 4'hF, 1'b0, 32'h80 + 4 * i1, 32'h0);
            else        drive(1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
         end
      end
      drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      n_tests++;
      if (nresp != 8 || rsp_cnt - rsp0 != 8 || q_cyc.size() != 0) begin
         n_fail++;
         $display("FAIL rr_count got %0d responses, %0d pulse cycles, %0d pending required 8, 8, 0",
                  nresp, rsp_cnt - rsp0, q_cyc.size());
      end
   endtask

   task automatic test_withdraw();
      req_t a, tab [3];
      bit ok, e_err;
      logic id, err;
      logic [31:0] rd, e_rd;
      int lat, acc, rdy0, r10;
      rdy0 = p1_rdy_cnt;
      r10  = rsp1_cnt;
      a = '{1'b0, 1'b1, 4'hF, 1'b0, 32'h60, $urandom};
      send(a, acc, ok);
      model(a.we, a.ty, a.sg, a.ad, a.wd, e_err, e_rd);
      drive(1, 1'b1, 1'b1, 4'hF, 1'b0, 32'h50, 32'h55AA55AA);
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 4'hF, 1'b0, 32'h50, 32'h55AA55AA);
      @(negedge clk);
      n_tests++;
      if ({ok, rsp_valid, rsp_id} !== 3'b110) begin
         n_fail++;
         $display("FAIL wd_first got accepted=%b rsp_valid=%b rsp_id=%b required 1 1 0", ok, rsp_valid, rsp_id);
      end
      @(posedge clk);
      #1;
      tab[0] = '{1'b0, 1'b0, 4'hF, 1'b0, 32'h50, 32'h0};
      tab[1] = '{1'b0, 1'b0, 4'hF, 1'b0, 32'h60, 32'h0};
      tab[2] = '{1'b0, 1'b1, 4'h3, 1'b0, 32'h52, 32'h0000BEEF};
      foreach (tab[k]) begin
         xact(tab[k], ok, id, err, rd, lat);
         model(tab[k].we, tab[k].ty, tab[k].sg, tab[k].ad, tab[k].wd, e_err, e_rd);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL withdraw[%0d] no accept or response within bound", k);
         end else if ({id, err, rd} !== {1'b0, e_err, e_rd} || lat != 2) begin
            n_fail++;
            $display("FAIL withdraw[%0d] got id=%b err=%b rdata=%h lat=%0d required id=0 err=%b rdata=%h lat=2",
                     k, id, err, rd, lat, e_err, e_rd);
         end
      end
      n_tests++;
      if (p1_rdy_cnt != rdy0 || rsp1_cnt != r10) begin
         n_fail++;
         $display("FAIL withdraw_p1 got %0d p1 grants, %0d p1 responses required 0 0",
                  p1_rdy_cnt - rdy0, rsp1_cnt - r10);
      end
   endtask

   task automatic test_reset_in_access();
      req_t w_old, w_new, rd_req;
      bit ok, e_err;
      logic id, err;
      logic [31:0] rd, e_rd;
      int lat, acc, seen;
      w_old  = '{1'b0, 1'b1, 4'hF, 1'b0, 32'h30, 32'hCAFEF00D};
      w_new  = '{1'b0, 1'b1, 4'hF, 1'b0, 32'h30, 32'h12345678};
      rd_req = '{1'b1, 1'b0, 4'hF, 1'b0, 32'h30, 32'h0};
      xact(w_old, ok, id, err, rd, lat);
      model(w_old.we, w_old.ty, w_old.sg, w_old.ad, w_old.wd, e_err, e_rd);
      send(w_new, acc, ok);
      n_tests++;
      if ({ok, ram_we, ram_addr} !== {2'b11, 32'h30}) begin
         n_fail++;
         $display("FAIL rst_acc_enter got accepted=%b ram_we=%b ram_addr=%h required 1 1 00000030",
                  ok, ram_we, ram_addr);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (ram_we !== 1'b0) begin
         n_fail++; $display("FAIL rst_acc_we got ram_we=%b required 0", ram_we);
      end
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL rst_acc_rsp got %0d response cycles required 0", seen);
      end
      @(posedge clk);
      #1;
      xact(rd_req, ok, id, err, rd, lat);
      model(rd_req.we, rd_req.ty, rd_req.sg, rd_req.ad, rd_req.wd, e_err, e_rd);
      n_tests++;
      if (!ok || {id, err, rd} !== {1'b1, 1'b0, e_err ? 32'h0 : 32'hCAFEF00D} || rd !== e_rd) begin
         n_fail++;
         $display("FAIL rst_acc_old got ok=%b id=%b err=%b rdata=%h required 1 1 0 cafef00d", ok, id, err, rd);
      end
   endtask

   task automatic test_random();
      logic [3:0] ty_tab [10];
      req_t r;
      bit ok, e_err;
      logic id, err;
      logic [31:0] rd, e_rd;
      int lat;
      ty_tab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h1, 4'hF, 4'h5, 4'h2, 4'h0, 4'h8};
      for (int k = 0; k < 40; k++) begin
         r.port = 1'($urandom);
         r.we   = 1'($urandom);
         r.ty   = ty_tab[$urandom_range(0, 9)];
         r.sg   = 1'($urandom);
         r.wd   = $urandom;
         case ($urandom_range(0, 3))
            0:       r.ad = 32'($urandom_range(0, 255));
            1:       r.ad = 32'($urandom_range(248, 255));
            2:       r.ad = 32'h100 + 32'($urandom_range(0, 1023));
            default: r.ad = 32'($urandom_range(192, 255));
         endcase
         xact(r, ok, id, err, rd, lat);
         model(r.we, r.ty, r.sg, r.ad, r.wd, e_err, e_rd);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL rand[%0d] no accept or response within bound", k);
         end else if ({id, err, rd} !== {r.port, e_err, e_rd} || lat != 2) begin
            n_fail++;
            $display("FAIL rand[%0d] port=%b we=%b type=%h addr=%h got id=%b err=%b rdata=%h lat=%0d required id=%b err=%b rdata=%h lat=2",
                     k, r.port, r.we, r.ty, r.ad, id, err, rd, lat, r.port, e_err, e_rd);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_write_read();
      test_sign_ext();
      test_errors();
      test_round_robin();
      test_withdraw();
      test_reset_in_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
